// File: rtl/core_isa_pkg.sv
// Shared RV32I definitions: instruction formats, major opcodes and the loader FSM states.
// Imported by the decoder and by the instruction encoder/loader.
package core_isa_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } ldr_state_e;

    // True when v is representable as a two's-complement number of 'bits' bits,
    // i.e. every bit from position bits-1 upwards is a copy of the sign.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] t;
        t = $signed(v) >>> (bits - 1);
        return (t == 32'sd0) || (t == -32'sd1);
    endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational RV32I encoder: packs decoded fields into a 32-bit word and flags
// immediates that do not fit the selected format.
module instr_field_encoder
    import core_isa_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_imm_err
);

    always_comb begin
        o_word    = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        o_imm_err = 1'b0;
        case (i_fmt)
            FMT_R: begin
                o_imm_err = 1'b0;
            end
            FMT_I: begin
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_imm_err = !fits_signed(i_imm, 12);
            end
            FMT_S: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_imm_err = !fits_signed(i_imm, 12);
            end
            FMT_B: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
                o_imm_err = !fits_signed(i_imm, 13) || i_imm[0];
            end
            FMT_U: begin
                o_word    = {i_imm[31:12], i_rd, i_opcode};
                o_imm_err = |i_imm[11:0];
            end
            FMT_J: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_imm_err = !fits_signed(i_imm, 21) || i_imm[0];
            end
            // Unknown format codes still produce an R-shaped word but are reported.
            default: begin
                o_imm_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts decoded instruction bundles, encodes them and streams the words into IMEM
// at consecutive byte addresses, with a one-deep output register under backpressure.
module instr_encoder_loader
    import core_isa_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err_imm,
    output logic [ADDR_W-1:0] err_addr
);

    ldr_state_e        r_state;
    logic [ADDR_W-1:0] r_next_addr;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_acc;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_done;
    logic              r_err_imm;
    logic [ADDR_W-1:0] r_err_addr;

    logic [31:0]       w_word;
    logic              w_imm_err;
    logic              w_slot_free;
    logic              w_in_ready;
    logic              w_accept;

    instr_field_encoder u_enc (
        .i_fmt     (in_fmt),
        .i_opcode  (in_opcode),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_funct3  (in_funct3),
        .i_funct7  (in_funct7),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_imm_err (w_imm_err)
    );

    // The output slot can take a new word when it is empty or being written this cycle.
    assign w_slot_free = !r_mem_we || mem_ready;
    assign w_in_ready  = (r_state == ST_LOAD) && (r_acc < r_num) && w_slot_free;
    assign w_accept    = in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_next_addr <= '0;
            r_num       <= '0;
            r_acc       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err_imm   <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_done <= 1'b0;

            if (r_mem_we && mem_ready) begin
                r_mem_we <= 1'b0;
            end

            if (w_accept) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_next_addr;
                r_mem_wdata <= w_word;
                r_next_addr <= r_next_addr + ADDR_W'(4);
                r_acc       <= r_acc + CNT_W'(1);
                if (w_imm_err) begin
                    r_err_imm <= 1'b1;
                    if (!r_err_imm) begin
                        r_err_addr <= r_next_addr;
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_next_addr <= base_addr;
                        r_num       <= num_instr;
                        r_acc       <= '0;
                        r_err_imm   <= 1'b0;
                        r_err_addr  <= '0;
                        r_state     <= (num_instr == '0) ? ST_FIN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Leave only once the last word has left the output register.
                    if ((r_acc == r_num) && w_slot_free) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err_imm   = r_err_imm;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader with a queue-based reference model
// computed from the RV32I field layout using plain arithmetic.
module tb_instr_encoder_loader;
    import core_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_instr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic        busy, done, err_imm;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_instr(num_instr), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err_imm(err_imm), .err_addr(err_addr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t wr_log[$];
    int  pass_cnt = 0;
    int  chk_cnt  = 0;
    int  cyc      = 0;

    logic [31:0] m_addr = 0, m_err_addr = 0;
    logic        m_err  = 0;
    int          m_acc  = 0, m_n = 0;
    int          busy_cnt = 0, done_cnt = 0;

    logic [2:0]  b_fmt [64];
    logic [6:0]  b_op  [64];
    logic [6:0]  b_f7  [64];
    logic [4:0]  b_rd  [64];
    logic [4:0]  b_rs1 [64];
    logic [4:0]  b_rs2 [64];
    logic [2:0]  b_f3  [64];
    logic [31:0] b_imm [64];

    int          rdy_mode   = 0;
    logic [31:0] stall_addr = 0;
    int          stall_left = 3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference encoder: fields are shifted into place arithmetically, and the range
    // rules are expressed as signed-integer intervals.
    function automatic logic [31:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
            output logic bad);
        logic [31:0] o, d, f, r1, r2, u, w;
        int s;
        o = 32'(op); d = 32'(rd) << 7; f = 32'(f3) << 12;
        r1 = 32'(rs1) << 15; r2 = 32'(rs2) << 20; u = imm; s = int'($signed(imm));
        bad = 1'b0;
        case (fmt)
            3'd1: begin
                w = ((u & 32'hFFF) << 20) | r1 | f | d | o;
                bad = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w = (((u >> 5) & 32'h7F) << 25) | r2 | r1 | f | ((u & 32'h1F) << 7) | o;
                bad = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | r2 | r1 | f
                    | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | o;
                bad = (s < -4096) || (s > 4095) || (u % 2 != 0);
            end
            3'd4: begin
                w = (u & 32'hFFFFF000) | d | o;
                bad = (u % 4096) != 0;
            end
            3'd5: begin
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                    | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | d | o;
                bad = (s < -1048576) || (s > 1048575) || (u % 2 != 0);
            end
            default: begin
                w = (32'(f7) << 25) | r2 | r1 | f | d | o;
                bad = (fmt > 3'd5);
            end
        endcase
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side responder: always ready, random, a 3-cycle stall on one address, or stuck.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: mem_ready = ($urandom_range(99) < 70);
            2: begin
                if (mem_we && mem_addr == stall_addr && stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            3: mem_ready = 1'b0;
            default: mem_ready = 1'b1;
        endcase
        if (rdy_mode != 2) stall_left = 3;
    end

    // Compare process: owns the model, checks every cycle while out of reset.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 0, prev_data = 0;
    always @(negedge clk) begin
        logic        bad;
        logic [31:0] w;
        wr_t         e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            if (start && !busy) begin
                m_addr = base_addr; m_n = int'(num_instr); m_acc = 0;
                m_err = 1'b0; m_err_addr = 0;
                busy_cnt = 0; done_cnt = 0;
                wr_log.delete();
                exp_q.delete();
            end
            if (prev_stall) begin
                chk("hold_we", 32'(mem_we), 1);
                chk("hold_addr", mem_addr, prev_addr);
                chk("hold_data", mem_wdata, prev_data);
            end
            if (mem_we && !mem_ready) chk("in_ready_stall", 32'(in_ready), 0);
            if (!busy || m_acc >= m_n) chk("in_ready_idle_full", 32'(in_ready), 0);
            if (mem_we && mem_ready) begin
                chk("write_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                end
                e.addr = mem_addr; e.data = mem_wdata; e.cyc = cyc;
                wr_log.push_back(e);
                $display("write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
            end
            if (in_valid && in_ready) begin
                w = ref_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
                               in_funct7, in_imm, bad);
                e.addr = m_addr; e.data = w; e.cyc = 0;
                exp_q.push_back(e);
                if (bad && !m_err) m_err_addr = m_addr;
                if (bad) m_err = 1'b1;
                m_addr = m_addr + 32'd4;
                m_acc++;
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end
    end

    task automatic set_b(input int i, input logic [2:0] fmt, input logic [6:0] op,
            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        b_fmt[i] = fmt; b_op[i] = op; b_rd[i] = rd; b_rs1[i] = rs1;
        b_rs2[i] = rs2; b_f3[i] = f3; b_f7[i] = f7; b_imm[i] = imm;
    endtask

    task automatic fill_random(input int n);
        logic [31:0] imm;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(8191)) - 32'd4096;
                2: imm = (32'($urandom_range(4095)) - 32'd2048) << 1;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            set_b(i, 3'($urandom_range(7)), 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), imm);
        end
    endtask

    task automatic drive_bundle(input int i);
        in_fmt = b_fmt[i]; in_opcode = b_op[i]; in_rd = b_rd[i]; in_rs1 = b_rs1[i];
        in_rs2 = b_rs2[i]; in_funct3 = b_f3[i]; in_funct7 = b_f7[i]; in_imm = b_imm[i];
    endtask

    task automatic send_bundles(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            int   tmo;
            logic got;
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            drive_bundle(i);
            in_valid = 1'b1;
            tmo = 0; got = 1'b0;
            while (!got && tmo < 200) begin
                @(negedge clk); got = in_ready;
                @(posedge clk); #1;
                tmo++;
            end
            if (!got) begin
                chk("accept_timeout", 32'(got), 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] base, input int n, input int gap_pct);
        int   tmo;
        logic got;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_instr = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        send_bundles(n, gap_pct);
        tmo = 0; got = 1'b0;
        while (!got && tmo < 400) begin
            @(negedge clk); got = done; tmo++;
        end
        chk("done_seen", 32'(got), 1);
        if (got) chk("busy_at_done", 32'(busy), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("writes_count", wr_log.size(), n);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("err_imm", 32'(err_imm), 32'(m_err));
        chk("err_addr", err_addr, m_err_addr);
        chk("done_count", done_cnt, 1);
        $display("job base=0x%08h n=%0d writes=%0d err_imm=%0b err_addr=0x%08h",
                 base, n, wr_log.size(), err_imm, err_addr);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err_imm"}, 32'(err_imm), 0);
        chk({tag, "_err_addr"}, err_addr, 0);
    endtask

    logic [31:0] lit_words [6];

    initial begin
        logic [31:0] w;
        logic        bad;
        int          n;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; base_addr = 0; num_instr = 0;
        in_fmt = 0; in_opcode = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        in_funct3 = 0; in_funct7 = 0; in_imm = 0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Directed program: addi, add, sw, beq, lui, jal.
        lit_words[0] = 32'h00500093; lit_words[1] = 32'h002081B3;
        lit_words[2] = 32'h0020A423; lit_words[3] = 32'hFE208EE3;
        lit_words[4] = 32'h123452B7; lit_words[5] = 32'h001000EF;
        set_b(0, 3'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        set_b(1, 3'd0, OPC_OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        set_b(2, 3'd2, OPC_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        set_b(3, 3'd3, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
        set_b(4, 3'd4, OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        set_b(5, 3'd5, OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        for (int i = 0; i < 6; i++) begin
            w = ref_encode(b_fmt[i], b_op[i], b_rd[i], b_rs1[i], b_rs2[i], b_f3[i],
                           b_f7[i], b_imm[i], bad);
            chk($sformatf("model_pin_%0d", i), w, lit_words[i]);
        end
        run_job(32'h100, 6, 0);
        for (int i = 0; i < wr_log.size() && i < 6; i++) begin
            chk($sformatf("lit_addr_%0d", i), wr_log[i].addr, 32'h100 + 32'(4 * i));
            chk($sformatf("lit_data_%0d", i), wr_log[i].data, lit_words[i]);
            chk($sformatf("lit_back2back_%0d", i), wr_log[i].cyc - wr_log[0].cyc, i);
        end

        // Three-cycle stall on the second word.
        rdy_mode = 2; stall_addr = 32'h204;
        fill_random(4);
        run_job(32'h200, 4, 0);
        chk("stall_applied", stall_left, 0);
        rdy_mode = 0;

        // Two range errors: only the first address is recorded.
        set_b(0, 3'd1, OPC_OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
        set_b(1, 3'd3, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd3);
        run_job(32'h40, 2, 0);
        chk("lit_err_imm", 32'(err_imm), 1);
        chk("lit_err_addr", err_addr, 32'h40);

        // Empty job.
        run_job(32'h200, 0, 0);
        chk("empty_busy_cycles", busy_cnt, 1);

        // Address wrap.
        fill_random(2);
        run_job(32'hFFFFFFFC, 2, 0);
        if (wr_log.size() == 2) begin
            chk("wrap_addr0", wr_log[0].addr, 32'hFFFFFFFC);
            chk("wrap_addr1", wr_log[1].addr, 32'h00000000);
        end

        // Random jobs under random backpressure and input gaps.
        rdy_mode = 1;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(12, 1);
            fill_random(n);
            run_job($urandom, n, 30);
        end

        // Reset while the first word of four is stalled.
        rdy_mode = 3;
        fill_random(4);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h300; num_instr = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        send_bundles(1, 0);
        drive_bundle(1);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_stalled_we", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("no_done_in_reset", 32'(done), 0);
        end
        rdy_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_no_write", 32'(mem_we), 0);
            chk("post_reset_no_done", 32'(done), 0);
        end
        fill_random(3);
        run_job(32'h400, 3, 20);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Reverse direction of the core's instruction decode path: accepts decoded instruction fields, re-encodes them into 32-bit RV32I words, and writes them sequentially into instruction memory.
- Used by the boot/test loader and self-test sequencer to build programs in IMEM without an external assembler.
- Controlled by a start/num_instr job interface.
- Field input uses a valid/ready handshake; the memory write port uses we/ready backpressure.

Parameters:
- ADDR_W, 32, byte-address width of the IMEM write port.
- CNT_W, 16, width of the instruction-count register.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  job start pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first byte address; captured on start
- num_instr  in  CNT_W  words in the job; captured on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  field bundle accepted when in_valid&in_ready
- in_fmt  in  3  format code: R=0, I=1, S=2, B=3, U=4, J=5
- in_opcode  in  7  opcode
- in_rd / in_rs1 / in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field
- in_imm  in  32  immediate as signed byte value; U format supplies the full upper value
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  32  encoded word
- mem_ready  in  1  memory accepts when mem_we&mem_ready
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on job completion
- err_imm  out  1  sticky immediate-range error; cleared on start
- err_addr  out  ADDR_W  address of the first offending word

Behaviour:
- Reset: FSM to IDLE; all outputs 0 (in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_imm, err_addr); internal counters 0.
- FSM IDLE:
  - On start, capture base_addr and num_instr, clear err_imm and err_addr.
  - Go to LOAD, or to FIN if num_instr==0.
  - start outside IDLE is ignored.
- FSM LOAD: accept bundles until accepted count == num_instr. Then wait for the output register to drain and go to FIN.
- FSM FIN: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle done is high.
- Handshake: in_ready = LOAD && accepted<num_instr && (!mem_we || mem_ready).
- Output register: single stage. An accepted bundle drives mem_we/mem_addr/mem_wdata on the next cycle (latency 1).
- Backpressure: while mem_we&&!mem_ready, mem_we, mem_addr and mem_wdata are held stable. Accept and write may complete in the same cycle, giving full throughput of one word/cycle.
- Address: first write at base_addr; +4 per accepted word; wraps modulo 2^ADDR_W.
- Encoding, per RV32I field layout:
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - Unused fields are ignored. in_fmt values 6-7 encode as R and set err_imm.
- Range check (flags an error; the truncated word is still written):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
  - On failure: err_imm<=1. err_addr captures this word's address only if err_imm was 0.
- Reset mid-job: abandons the job immediately. No done pulse, and no further writes.

Decomposition:
- Shared package core_isa_pkg holds:
  - instr_fmt_e enum (R,I,S,B,U,J)
  - RV32I opcode constants OPC_OP, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_JAL
  - The decoder uses the same package.
- Sub-module instr_field_encoder: purely combinational. Maps fields plus fmt to {word, imm_err}. The top holds the FSM, counters and output register.

Test Plan:
- start base=0x100, n=6, mem_ready=1, bundles below -> words at 0x100..0x114, one per cycle, then done pulse, err_imm=0:
  - addi x1,x0,5 -> 0x00500093
  - add x3,x1,x2 -> 0x002081B3
  - sw x2,8(x1) -> 0x0020A423
  - beq x1,x2,-4 -> 0xFE208EE3
  - lui x5,0x12345000 -> 0x123452B7
  - jal x1,2048 -> 0x001000EF
- mem_ready low 3 cycles during word 2 -> mem_addr/mem_wdata/mem_we stable, in_ready=0, no word lost or duplicated.
- I-type imm=2048 as word 1 at base 0x40, then B-type imm=3 -> err_imm=1, err_addr=0x40 (not overwritten by the second error), both words still written.
- num_instr=0 -> no mem_we; done one cycle after start; busy high for exactly 1 cycle.
- base_addr=0xFFFFFFFC, n=2 -> writes at 0xFFFFFFFC then 0x00000000.
- rst_n low while word 1 of 4 is stalled -> all outputs 0 immediately; no done; a new start after reset runs normally.
